// File: rtl/ddr_game_controller.sv
// ddr_game_controller: DDR game FSM, beat-synchronous move judging, lives/score/combo tracking
module ddr_game_controller #(
    parameter int NUM_ARROWS_BITS = 4,
    parameter int STATE_BITS      = 1,
    parameter int START_LIVES     = 5,
    parameter int ARROW_NONE      = 20,
    parameter int SCORE_MAX       = 9999
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     metronome_clk,
    input  logic                     start_btn,
    input  logic                     pause_btn,
    input  logic [NUM_ARROWS_BITS:0] cur_arrow3,
    input  logic [NUM_ARROWS_BITS:0] player_move,
    input  logic                     player_valid,
    output logic [STATE_BITS:0]      state,
    output logic [2:0]               lives,
    output logic [13:0]              score,
    output logic [13:0]              combo,
    output logic [13:0]              max_combo,
    output logic                     hit_pulse,
    output logic                     miss_pulse
);
    typedef enum logic [STATE_BITS:0] {IDLE, GAME, PAUSE, OVER} state_t;
    localparam logic [NUM_ARROWS_BITS:0] NONE = (NUM_ARROWS_BITS+1)'(ARROW_NONE);
    localparam logic [13:0] SMAX = 14'(SCORE_MAX);
    localparam logic [2:0] LIVES0 = 3'(START_LIVES);
    state_t cur, nxt;
    logic m1, m2, m3, beat, judge, hit, miss, got, got_n;
    logic [NUM_ARROWS_BITS:0] cap, cap_n;
    logic [2:0] lives_n;
    logic [13:0] score_n, combo_n, max_n;
    assign state = cur;
    assign beat  = m2 & ~m3;
    // a captured NONE means no move was made this window
    assign judge = cur == GAME && beat && !(cur_arrow3 == NONE && cap == NONE);
    assign hit   = judge && cap == cur_arrow3;
    assign miss  = judge && !hit;
    always_ff @(posedge clk)
        if (!rst_n) cur <= IDLE;
        else cur <= nxt;
    always_ff @(posedge clk)
        if (!rst_n) begin
            {m3, m2, m1} <= '0;
            lives        <= LIVES0;
            score        <= '0;
            combo        <= '0;
            max_combo    <= '0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            cap          <= NONE;
            got          <= 1'b0;
        end else begin
            {m3, m2, m1} <= {m2, m1, metronome_clk};
            lives        <= lives_n;
            score        <= score_n;
            combo        <= combo_n;
            max_combo    <= max_n;
            hit_pulse    <= hit;
            miss_pulse   <= miss;
            cap          <= cap_n;
            got          <= got_n;
        end
    always_comb begin
        nxt     = cur;
        lives_n = lives;
        score_n = score;
        combo_n = combo;
        max_n   = max_combo;
        cap_n   = cap;
        got_n   = got;
        case (cur)
            IDLE: if (start_btn) begin
                nxt     = GAME;
                lives_n = LIVES0;
                score_n = '0;
                combo_n = '0;
                max_n   = '0;
            end
            GAME: begin
                if (hit) begin
                    score_n = score >= SMAX ? SMAX : score + 14'd1;
                    combo_n = combo >= SMAX ? SMAX : combo + 14'd1;
                    max_n   = combo_n > max_combo ? combo_n : max_combo;
                end
                if (miss) begin
                    lives_n = lives == 3'd0 ? lives : lives - 3'd1;
                    combo_n = '0;
                end
                nxt = lives_n == 3'd0 ? OVER : pause_btn ? PAUSE : GAME;
                // a strobe on the beat cycle opens the next window
                cap_n = beat ? (player_valid ? player_move : NONE) : (player_valid && !got ? player_move : cap);
                got_n = beat ? player_valid : got | player_valid;
            end
            PAUSE: nxt = pause_btn ? GAME : PAUSE;
            default: nxt = start_btn ? IDLE : OVER;
        endcase
        if (nxt != GAME) begin
            cap_n = NONE;
            got_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_ddr_game_controller.sv
// tb_ddr_game_controller: randomized and directed checks against a queue-based game model
module tb_ddr_game_controller;
    localparam int SMAX = 20;
    localparam int NONE = 20;
    localparam int S_IDLE = 0, S_GAME = 1, S_PAUSE = 2, S_OVER = 3;
    logic clk = 0, rst_n = 0, metronome_clk = 0, start_btn = 0, pause_btn = 0, player_valid = 0;
    logic [4:0] cur_arrow3 = '0, player_move = '0;
    logic [1:0] state;
    logic [2:0] lives;
    logic [13:0] score, combo, max_combo;
    logic hit_pulse, miss_pulse;
    int checks = 0, fails = 0;
    int ms = S_IDLE, ml = 5, sc = 0, cb = 0, mx = 0;
    int win[$];
    int n_hits = 0, n_miss = 0, seen_hits = 0, seen_miss = 0;
    bit exp_hit, exp_miss, ph, pm;

    always #5 clk = ~clk;

    ddr_game_controller #(.SCORE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .metronome_clk(metronome_clk), .start_btn(start_btn),
        .pause_btn(pause_btn), .cur_arrow3(cur_arrow3), .player_move(player_move),
        .player_valid(player_valid), .state(state), .lives(lives), .score(score),
        .combo(combo), .max_combo(max_combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always @(negedge clk) begin
        if (hit_pulse === 1'b1) seen_hits++;
        if (miss_pulse === 1'b1) seen_miss++;
    end

    function automatic logic [46:0] snap();
        return {state, lives, score, combo, max_combo};
    endfunction

    function automatic logic [46:0] mexp();
        return {2'(ms), 3'(ml), 14'(sc), 14'(cb), 14'(mx)};
    endfunction

    // game rules for one clock cycle of inputs
    task automatic mstep(bit bt, int arrow, bit v, int mv, bit st, bit pa);
        int m;
        exp_hit = 0;
        exp_miss = 0;
        case (ms)
            S_IDLE: if (st) begin
                ms = S_GAME; ml = 5; sc = 0; cb = 0; mx = 0; win.delete();
            end
            S_GAME: begin
                if (bt) begin
                    m = win.size() > 0 ? win[0] : NONE;
                    win.delete();
                    if (!(arrow == NONE && m == NONE)) begin
                        if (m == arrow) begin
                            exp_hit = 1; n_hits++;
                            sc = sc + 1 > SMAX ? SMAX : sc + 1;
                            cb = cb + 1 > SMAX ? SMAX : cb + 1;
                            mx = cb > mx ? cb : mx;
                        end else begin
                            exp_miss = 1; n_miss++;
                            ml = ml > 0 ? ml - 1 : 0;
                            cb = 0;
                        end
                    end
                end
                if (v) win.push_back(mv);
                if (ml == 0) begin ms = S_OVER; win.delete(); end
                else if (pa) begin ms = S_PAUSE; win.delete(); end
            end
            S_PAUSE: if (pa) ms = S_GAME;
            default: if (st) ms = S_IDLE;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 0;
        tick();
        rst_n = 1;
        ms = S_IDLE; ml = 5; sc = 0; cb = 0; mx = 0;
        win.delete();
    endtask

    task automatic press(bit st, bit pa);
        start_btn = st;
        pause_btn = pa;
        tick();
        start_btn = 0;
        pause_btn = 0;
        mstep(0, 0, 0, 0, st, pa);
    endtask

    task automatic strobe(int mv);
        player_move = 5'(mv);
        player_valid = 1;
        tick();
        player_valid = 0;
        mstep(0, 0, 1, mv, 0, 0);
    endtask

    // metronome rise; optional strobe/pause coincide with the beat cycle
    task automatic beat(int arrow, bit cv = 0, int cm = 0, bit pb = 0);
        cur_arrow3 = 5'(arrow);
        metronome_clk = 1;
        tick();
        tick();
        player_valid = cv;
        player_move = 5'(cm);
        pause_btn = pb;
        tick();
        ph = hit_pulse;
        pm = miss_pulse;
        mstep(1, arrow, cv, cm, 0, pb);
        player_valid = 0;
        pause_btn = 0;
        metronome_clk = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (snap() !== mexp()) begin fails++; $display("FAIL reset_outputs: got %h expected %h", snap(), mexp()); end
        checks++; if ({state, lives, hit_pulse, miss_pulse} !== {2'd0, 3'd5, 2'b00}) begin fails++; $display("FAIL reset_state: got %h expected %h", {state, lives, hit_pulse, miss_pulse}, {2'd0, 3'd5, 2'b00}); end
    endtask

    task automatic test_hits();
        reset_dut();
        press(1, 0);
        for (int i = 0; i < 3; i++) begin
            strobe(2);
            beat(2);
            checks++; if ({ph, pm} !== {exp_hit, exp_miss}) begin fails++; $display("FAIL hit_pulse[%0d]: got %b expected %b", i, {ph, pm}, {exp_hit, exp_miss}); end
            checks++; if (snap() !== mexp()) begin fails++; $display("FAIL hit_counters[%0d]: got %h expected %h", i, snap(), mexp()); end
        end
        checks++; if ({score, combo, max_combo, lives} !== {14'd3, 14'd3, 14'd3, 3'd5}) begin fails++; $display("FAIL three_hits: got %h expected %h", {score, combo, max_combo, lives}, {14'd3, 14'd3, 14'd3, 3'd5}); end
    endtask

    task automatic test_miss_combo();
        reset_dut();
        press(1, 0);
        strobe(1); beat(1);
        strobe(1); beat(1);
        beat(1);
        checks++; if ({ph, pm} !== 2'b01) begin fails++; $display("FAIL missing_move_pulse: got %b expected 01", {ph, pm}); end
        checks++; if ({combo, max_combo, lives} !== {14'd0, 14'd2, 3'd4}) begin fails++; $display("FAIL combo_break: got %h expected %h", {combo, max_combo, lives}, {14'd0, 14'd2, 3'd4}); end
        checks++; if (snap() !== mexp()) begin fails++; $display("FAIL combo_model: got %h expected %h", snap(), mexp()); end
    endtask

    task automatic test_game_over();
        reset_dut();
        press(1, 0);
        for (int i = 0; i < 5; i++) begin
            strobe(3);
            beat(0);
            checks++; if ({ph, pm, lives} !== {2'b01, 3'(4 - i)}) begin fails++; $display("FAIL wrong_move[%0d]: got %h expected %h", i, {ph, pm, lives}, {2'b01, 3'(4 - i)}); end
        end
        checks++; if (state !== 2'd3) begin fails++; $display("FAIL game_over_state: got %0d expected 3", state); end
        for (int i = 0; i < 2; i++) begin
            strobe(1);
            beat(1);
            checks++; if ({ph, pm} !== 2'b00 || snap() !== mexp()) begin fails++; $display("FAIL over_beat[%0d]: got %h expected %h", i, snap(), mexp()); end
        end
        press(1, 0);
        checks++; if ({state, lives} !== {2'd0, 3'd0}) begin fails++; $display("FAIL over_to_idle: got %h expected %h", {state, lives}, {2'd0, 3'd0}); end
        press(1, 0);
        checks++; if ({state, lives, score} !== {2'd1, 3'd5, 14'd0}) begin fails++; $display("FAIL restart: got %h expected %h", {state, lives, score}, {2'd1, 3'd5, 14'd0}); end
    endtask

    task automatic test_window();
        reset_dut();
        press(1, 0);
        strobe(2);
        strobe(3);
        beat(2);
        checks++; if ({ph, pm} !== 2'b10) begin fails++; $display("FAIL first_strobe_wins: got %b expected 10", {ph, pm}); end
        beat(1, 1, 3);
        checks++; if ({ph, pm} !== 2'b01) begin fails++; $display("FAIL coincident_not_now: got %b expected 01", {ph, pm}); end
        beat(3);
        checks++; if ({ph, pm} !== 2'b10) begin fails++; $display("FAIL coincident_next: got %b expected 10", {ph, pm}); end
        checks++; if (snap() !== mexp()) begin fails++; $display("FAIL window_model: got %h expected %h", snap(), mexp()); end
    endtask

    task automatic test_pause();
        reset_dut();
        press(1, 0);
        strobe(2); beat(2);
        press(0, 1);
        checks++; if (state !== 2'd2) begin fails++; $display("FAIL enter_pause: got %0d expected 2", state); end
        for (int i = 0; i < 4; i++) begin
            strobe(1);
            beat(1);
            checks++; if ({ph, pm} !== 2'b00 || snap() !== mexp()) begin fails++; $display("FAIL paused_beat[%0d]: got %h expected %h", i, snap(), mexp()); end
        end
        press(0, 1);
        strobe(1); beat(1);
        checks++; if ({ph, pm, score} !== {2'b10, 14'd2}) begin fails++; $display("FAIL resume_judge: got %h expected %h", {ph, pm, score}, {2'b10, 14'd2}); end
        beat(NONE);
        checks++; if ({ph, pm} !== 2'b00 || snap() !== mexp()) begin fails++; $display("FAIL none_arrow: got %h expected %h", snap(), mexp()); end
        strobe(2);
        beat(2, 0, 0, 1);
        checks++; if ({ph, pm, state, score} !== {2'b10, 2'd2, 14'd3}) begin fails++; $display("FAIL beat_then_pause: got %h expected %h", {ph, pm, state, score}, {2'b10, 2'd2, 14'd3}); end
        press(1, 1);
        checks++; if (state !== 2'd1) begin fails++; $display("FAIL start_pause_in_pause: got %0d expected 1", state); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        press(1, 0);
        repeat (7) begin strobe(0); beat(0); end
        repeat (3) beat(2);
        checks++; if ({score, lives} !== {14'd7, 3'd2} || snap() !== mexp()) begin fails++; $display("FAIL pre_reset: got %h expected %h", snap(), mexp()); end
        reset_dut();
        checks++; if ({state, lives, score, combo, max_combo} !== {2'd0, 3'd5, 42'd0}) begin fails++; $display("FAIL mid_game_reset: got %h expected %h", snap(), {2'd0, 3'd5, 42'd0}); end
    endtask

    task automatic test_saturation();
        reset_dut();
        press(1, 1);
        checks++; if (state !== 2'd1) begin fails++; $display("FAIL start_beats_pause: got %0d expected 1", state); end
        repeat (SMAX + 3) begin strobe(1); beat(1); end
        checks++; if ({ph, score, combo, max_combo} !== {1'b1, 14'(SMAX), 14'(SMAX), 14'(SMAX)}) begin fails++; $display("FAIL saturation: got %h expected %h", {ph, score, combo, max_combo}, {1'b1, 14'(SMAX), 14'(SMAX), 14'(SMAX)}); end
        checks++; if (snap() !== mexp()) begin fails++; $display("FAIL saturation_model: got %h expected %h", snap(), mexp()); end
    endtask

    task automatic test_random();
        int arrow;
        reset_dut();
        press(1, 0);
        for (int i = 0; i < 80; i++) begin
            if (ms == S_OVER || ms == S_IDLE) begin press(1, 0); press(1, 0); press(1, 0); end
            if ($urandom_range(0, 9) == 0) press(0, 1);
            arrow = $urandom_range(0, 5) == 0 ? NONE : int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) strobe($urandom_range(0, 1) ? (arrow == NONE ? 0 : arrow) : int'($urandom_range(0, 3)));
            beat(arrow, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 11) == 0);
            checks++; if ({ph, pm} !== {exp_hit, exp_miss}) begin fails++; $display("FAIL random_pulse[%0d]: got %b expected %b", i, {ph, pm}, {exp_hit, exp_miss}); end
            checks++; if (snap() !== mexp()) begin fails++; $display("FAIL random_state[%0d]: got %h expected %h", i, snap(), mexp()); end
        end
    endtask

    initial begin
        test_reset();
        test_hits();
        test_miss_combo();
        test_game_over();
        test_window();
        test_pause();
        test_reset_mid();
        test_saturation();
        test_random();
        repeat (3) tick();
        checks++; if ({seen_hits, seen_miss} !== {n_hits, n_miss}) begin fails++; $display("FAIL pulse_counts: got %0d/%0d expected %0d/%0d", seen_hits, seen_miss, n_hits, n_miss); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ddr_game_controller.md
Name: ddr_game_controller

Overview:
- Central sequencer for the DDR game: owns the game state machine, judges the player's move against the live arrow on every metronome beat, and maintains lives, score and combo.
- Its outputs feed the seven-segment display logic, which only renders; all decrements and game-over decisions are made here.
- Sits between the arrow generator/metronome and the display/button front end.

Parameters:
- NUM_ARROWS_BITS, 4, arrow code width is NUM_ARROWS_BITS+1 bits.
- STATE_BITS, 1, state width is STATE_BITS+1 bits.
- START_LIVES, 5, lives loaded at game start (3-bit value, 1..7).
- ARROW_NONE, 20, arrow code meaning "no arrow / no move".
- SCORE_MAX, 9999, saturation limit for score, combo and max_combo (14-bit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- metronome_clk  in  1  beat clock, asynchronous to clk, slow square wave.
- start_btn  in  1  debounced single-cycle pulse.
- pause_btn  in  1  debounced single-cycle pulse.
- cur_arrow3  in  NUM_ARROWS_BITS+1  arrow the player must match this beat.
- player_move  in  NUM_ARROWS_BITS+1  move code from input decoder.
- player_valid  in  1  single-cycle strobe qualifying player_move.
- state  out  STATE_BITS+1  0=IDLE, 1=GAME, 2=PAUSE, 3=OVER.
- lives  out  3  remaining lives.
- score  out  14  hit count.
- combo  out  14  consecutive hits.
- max_combo  out  14  best combo this game.
- hit_pulse  out  1  one-cycle pulse on a judged hit.
- miss_pulse  out  1  one-cycle pulse on a judged miss.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, lives=START_LIVES, score/combo/max_combo=0, pulses=0, captured move=ARROW_NONE, sync flops=0. Reset mid-game aborts with no judgement.
- Beat detect: metronome_clk goes through flops m1->m2->m3; beat = m2 & ~m3. A metronome high first sampled at edge N gives beat=1 during cycle N+1; all judgement results are visible after edge N+2.
- Move capture, GAME only: the first player_valid in a beat window latches player_move. Later strobes in the same window are ignored. A strobe in the same cycle as beat belongs to the next window. The captured move is reset to ARROW_NONE at each beat.
- Judgement at beat in GAME:
  - cur_arrow3==ARROW_NONE and captured==ARROW_NONE: no change, no pulse.
  - captured==cur_arrow3 (not NONE): hit. score+1 and combo+1, each saturating at SCORE_MAX. max_combo=max(max_combo, new combo). hit_pulse=1.
  - Otherwise (wrong move, missing move, or a press on a NONE arrow): miss. lives-1, combo=0, miss_pulse=1.
- lives never underflows. A miss at lives==1 gives lives=0 and state=OVER on the same edge.
- FSM transitions:
  - IDLE --start_btn--> GAME: lives=START_LIVES, score/combo/max_combo=0, captured move cleared.
  - GAME --pause_btn--> PAUSE: captured move discarded.
  - PAUSE --pause_btn--> GAME.
  - GAME --lives reaches 0--> OVER.
  - OVER --start_btn--> IDLE. All counters hold until the next game start.
- Beats in IDLE, PAUSE or OVER: ignored. No judgement and no pulses.
- Simultaneous events:
  - start_btn and pause_btn in the same cycle: start wins where legal (IDLE, OVER); otherwise pause is evaluated.
  - pause_btn and beat in the same cycle in GAME: the beat is judged first, then the state goes to PAUSE. If that judgement produced lives=0, OVER wins.
- All outputs are registered. Pulses last exactly one cycle.

Test Plan:
- Reset, start_btn, 3 beats, each with player_move matching cur_arrow3=2 -> score=3, combo=3, max_combo=3, lives=5, three hit_pulses each 2 cycles after the metronome edge.
- Start, hit, hit, then a beat with no move on arrow=1 -> combo=0, max_combo=2, lives=4, one miss_pulse.
- Start, 5 consecutive wrong moves -> lives 4,3,2,1,0; state=OVER on the 5th judgement; further beats change nothing; start_btn -> IDLE, then start_btn -> GAME with lives=5, score=0.
- In GAME, two valid strobes in one window (first correct, second wrong) -> hit. Also a strobe coincident with beat -> counted in the next window only.
- pause_btn during GAME, 4 beats, pause_btn again -> no counter change while in PAUSE; judging resumes afterwards. A beat with arrow=ARROW_NONE and no move -> no pulse, no change.
- rst_n low during GAME with score=7, lives=2 -> next cycle IDLE, lives=5, score=0. Force score=9999 and hit -> score stays 9999.
